run_ctrl: RTL

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 17 +
 rtl/run_ctrl_rst_seq.sv | 29 ++
 rtl/run_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: state encoding and reset-release thresholds.
// Benches and the core top import this package to decode controller state.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // Release-count value at which reset domain k is let go.
  function automatic int rel_thr(input int k, input int cycles, input int stagger);
    return cycles + k * stagger;
  endfunction

endpackage

// File: rtl/run_ctrl_rst_seq.sv
// Staggered reset release: each domain's reset drops when the release count
// reaches its own threshold, and stays low until the next load.
module run_ctrl_rst_seq
  import run_ctrl_pkg::*;
#(
  parameter int N_RST       = 2,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 1,
  parameter int RST_STAGGER = 2
) (
  input  logic             clk,
  input  logic             load,
  input  logic             adv,
  input  logic [CNT_W-1:0] rel_cnt_nxt,
  output logic [N_RST-1:0] o_rst
);

  always_ff @(posedge clk) begin
    if (load) begin
      o_rst <= '1;
    end else if (adv) begin
      for (int k = 0; k < N_RST; k++) begin
        if (rel_cnt_nxt == CNT_W'(rel_thr(k, RST_CYCLES, RST_STAGGER)))
          o_rst[k] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences core resets, counts cycles, and records halt,
// pass and timeout for one run, with restart back into the reset sequence.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int N_RST       = 2,
  parameter int RST_CYCLES  = 1,
  parameter int RST_STAGGER = 2,
  parameter int MAX_CYCLES  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_halt,
  input  logic             i_pass,
  input  logic             i_restart,
  output logic [N_RST-1:0] o_rst,
  output logic [CNT_W-1:0] o_counter,
  output logic             o_running,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_timeout
);

  localparam int LAST_THR = RST_CYCLES + (N_RST - 1) * RST_STAGGER;
  localparam logic [CNT_W-1:0] LAST_THR_C = CNT_W'(LAST_THR);
  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  if (N_RST < 1) begin : g_bad_nrst
    $error("run_ctrl: N_RST must be at least 1");
  end
  if (MAX_CYCLES < 0 || (CNT_W < 32 && MAX_CYCLES >= (1 << CNT_W))) begin : g_bad_max
    $error("run_ctrl: MAX_CYCLES does not fit in CNT_W bits");
  end
  if (MAX_CYCLES <= LAST_THR) begin : g_bad_seq
    $error("run_ctrl: MAX_CYCLES must exceed the full reset release time");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rel_q, rel_nxt;
  logic             reload, at_max, inc, adv;
  logic             running_d, done_d, timeout_d;

  assign rel_nxt = rel_q + ONE_C;
  assign at_max  = (o_counter == MAX_C);
  assign reload  = rst || (((state_q == ST_HALTED) || (state_q == ST_TIMEOUT)) && i_restart);
  assign adv     = !reload && (state_q == ST_RESET);
  // Counter runs in RESET/RUN except on the edge that parks it in TIMEOUT.
  assign inc     = ((state_q == ST_RESET) || (state_q == ST_RUN)) && (state_d != ST_TIMEOUT);

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (at_max)                       state_d = ST_TIMEOUT;
          else if (rel_nxt == LAST_THR_C)   state_d = ST_RUN;
        end
        ST_RUN: begin
          if (i_halt)                       state_d = ST_HALTED;
          else if (at_max)                  state_d = ST_TIMEOUT;
        end
        ST_HALTED, ST_TIMEOUT: begin
          if (i_restart)                    state_d = ST_RESET;
        end
        default:                            state_d = ST_RESET;
      endcase
    end
  end

  always_comb begin
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_HALTED) || (state_d == ST_TIMEOUT);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    o_running <= running_d;
    o_done    <= done_d;
    o_timeout <= timeout_d;

    if (reload)   o_counter <= ONE_C;
    else if (inc) o_counter <= o_counter + ONE_C;

    if (reload)                   rel_q <= '0;
    else if (state_q == ST_RESET) rel_q <= rel_nxt;

    if (reload)                          o_pass <= 1'b0;
    else if (state_q == ST_RUN && i_halt) o_pass <= i_pass;
  end

  run_ctrl_rst_seq #(
    .N_RST      (N_RST),
    .CNT_W      (CNT_W),
    .RST_CYCLES (RST_CYCLES),
    .RST_STAGGER(RST_STAGGER)
  ) u_rst_seq (
    .clk        (clk),
    .load       (reload),
    .adv        (adv),
    .rel_cnt_nxt(rel_nxt),
    .o_rst      (o_rst)
  );

endmodule
